fifo_sync_flags: RTL and testbench
==================================

Name: fifo_sync_flags

Overview:
Parametrised single-clock FIFO. It succeeds the basic synchronous RAM FIFO and adds the following:
- occupancy count
- programmable almost-full and almost-empty thresholds
- overflow and underflow error pulses
- synchronous flush
- selectable read mode: first-word-fall-through or registered.

It sits between producer and consumer datapath stages in the same clock domain.

Parameters:
- DATA_WIDTH, 8: width of w_data and r_data.
- ADDR_WIDTH, 3: log2 of depth; DEPTH = 2**ADDR_WIDTH entries.
- AF_THRESH, 6: almost_full asserts when count >= AF_THRESH. Legal range 1..DEPTH.
- AE_THRESH, 1: almost_empty asserts when count <= AE_THRESH. Legal range 0..DEPTH-1.
- FWFT, 1: 1 = first-word-fall-through read mode; 0 = registered read mode with one-cycle latency.

Ports:
- clk, in, 1: rising-edge clock.
- reset, in, 1: synchronous, active-high reset.
- flush, in, 1: synchronous clear of FIFO contents (pointers and count); does not clear storage.
- wr, in, 1: write request.
- w_data, in, DATA_WIDTH: write data.
- rd, in, 1: read request (pop).
- r_data, out, DATA_WIDTH: read data.
- r_valid, out, 1: r_data holds valid data.
- empty, out, 1: count == 0.
- full, out, 1: count == DEPTH.
- almost_empty, out, 1: count <= AE_THRESH.
- almost_full, out, 1: count >= AF_THRESH.
- count, out, ADDR_WIDTH+1: current occupancy, 0..DEPTH.
- overflow, out, 1: one-cycle pulse when a write is dropped.
- underflow, out, 1: one-cycle pulse when a read is rejected.

Behaviour:
- Reset (reset=1 at a rising edge):
  - w_ptr, r_ptr and count go to 0.
  - empty=1, almost_empty=1 (AE_THRESH>=0), full=0, almost_full=0.
  - overflow=0, underflow=0, r_valid=0, r_data=0.
  - reset has priority over flush, wr and rd.
- Reset mid-operation discards all contents. Storage is not cleared, but it is unreachable until rewritten.
- Flush: same effect as reset on pointers, count, flags and r_valid. It does not clear r_data and does not clear the RAM.
  - Priority: flush over wr/rd. wr/rd in the flush cycle are ignored and raise no error pulses.
- Pointers are ADDR_WIDTH+1 bits wide. The MSB is the wrap bit, so wrap-around is natural modulo-2*DEPTH arithmetic.
- Write acceptance: wr_ok = wr & (!full | rd_ok).
- Read acceptance: rd_ok = rd & !empty.
- Simultaneous wr and rd when full: both accepted; count unchanged; the write goes to the slot freed by the read.
- Simultaneous wr and rd when empty: the write is accepted, the read is rejected, underflow pulses; count becomes 1.
- overflow is registered: it is 1 in the cycle after an edge where wr=1 and the write was not accepted.
- underflow is registered the same way, for an edge where rd=1 and empty=1.
- count update: count_next = count + wr_ok - rd_ok.
  - All flags are registered, derived from count_next, and update on the same edge as count.
  - No combinational path from wr/rd to any flag.
- FWFT=1:
  - r_data = mem[r_ptr] through an asynchronous read of the register array.
  - r_valid = !empty.
  - rd acknowledges the currently presented word; the next word appears after the edge.
  - Write-to-r_valid latency is 1 cycle.
- FWFT=0:
  - On an edge with rd_ok, r_data <= mem[r_ptr] and r_valid <= 1.
  - Otherwise r_valid <= 0 and r_data holds its value.
  - Read latency is 1 cycle; write-to-readable latency is 1 cycle.
- Thresholds are checked at elaboration. An out-of-range value stops elaboration with an error message.

Decomposition:
- Shared package fifo_pkg holds:
  - the depth and count-width helper functions (DEPTH = 2**ADDR_WIDTH, CNT_W = ADDR_WIDTH+1)
  - the read-mode constants MODE_FWFT=1 and MODE_REG=0
  - the threshold range-check function.
- Sub-module fifo_ram_dp: simple dual-port register array with parameters DATA_WIDTH and ADDR_WIDTH, synchronous write and asynchronous read.
- The top level holds pointers, count, flags and the read-mode register.

Test Plan (DATA_WIDTH=8, ADDR_WIDTH=3, AF=6, AE=1):
1. Reset, then write 8 words 0x11..0x88 with rd=0.
   - count steps 1..8.
   - almost_full rises on the edge where count reaches 6; full=1 at 8.
   - A 9th write (0x99) produces overflow=1 for one cycle; count stays 8.
2. Read 8 words from full.
   - FWFT=1: r_data sequence is 0x11..0x88.
   - FWFT=0: same sequence, each valid one cycle after its rd with r_valid=1.
   - Ends with empty=1; a further rd produces underflow=1 for one cycle and r_valid=0.
3. Hold rd=wr=1 for 20 cycles from count=0, writing an incrementing pattern.
   - Only the first cycle's read is rejected (underflow pulse); count holds at 1 thereafter.
   - Output order matches input order across pointer wrap.
4. Fill to full (8), then assert rd=wr=1 for one cycle.
   - No overflow; count=8.
   - The oldest word is popped and the new word lands at the tail; a read-out confirms the order.
5. With count=5, assert flush together with wr=1 and rd=1.
   - Next cycle: count=0, empty=1, almost_empty=1, no overflow or underflow pulse.
   - The next written word 0xA5 is the first word read.
6. With count=4, assert reset in the same cycle as wr=1.
   - All outputs return to their reset values; the write is discarded.
   - The FIFO then accepts 8 writes before full asserts.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types, sizing helpers and parameter checks for the flagged sync FIFO.
package fifo_pkg;

    // Read-mode selector values for the FWFT parameter
    localparam int unsigned MODE_REG  = 0;
    localparam int unsigned MODE_FWFT = 1;

    // Registered status flags presented alongside the count
    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
        logic overflow;
        logic underflow;
    } fifo_flags_t;

    // Number of storage entries for a given address width
    function automatic int unsigned fifo_depth(input int unsigned addr_width);
        return 32'(1) << addr_width;
    endfunction

    // Pointer/count width: one extra bit so 0..DEPTH and the wrap bit both fit
    function automatic int unsigned fifo_cnt_w(input int unsigned addr_width);
        return addr_width + 32'(1);
    endfunction

    // almost_full threshold must be reachable and non-trivial: 1..DEPTH
    function automatic bit af_thresh_ok(input int unsigned af, input int unsigned depth);
        return (af >= 32'(1)) && (af <= depth);
    endfunction

    // almost_empty threshold must leave room above it: 0..DEPTH-1
    function automatic bit ae_thresh_ok(input int unsigned ae, input int unsigned depth);
        return ae < depth;
    endfunction

    // Combined range check used at elaboration
    function automatic bit thresh_ok(input int unsigned af, input int unsigned ae,
                                     input int unsigned depth);
        return af_thresh_ok(af, depth) && ae_thresh_ok(ae, depth);
    endfunction

    // Flag vector for a given occupancy plus the error pulses of that edge
    function automatic fifo_flags_t make_flags(input int unsigned cnt,
                                               input int unsigned depth,
                                               input int unsigned af,
                                               input int unsigned ae,
                                               input logic        ovf,
                                               input logic        udf);
        fifo_flags_t f;
        f.empty        = (cnt == 32'(0));
        f.full         = (cnt == depth);
        f.almost_empty = (cnt <= ae);
        f.almost_full  = (cnt >= af);
        f.overflow     = ovf;
        f.underflow    = udf;
        return f;
    endfunction

endpackage

// File: rtl/fifo_sync_flags_if.sv
// Producer/consumer handshake and status bundle of the flagged sync FIFO.
interface fifo_sync_flags_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
);

    // Control and write side
    logic                  flush;
    logic                  wr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  rd;

    // Read side and status
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    // Datapath stages around the FIFO
    modport master (
        output flush,
        output wr,
        output w_data,
        output rd,
        input  r_data,
        input  r_valid,
        input  empty,
        input  full,
        input  almost_empty,
        input  almost_full,
        input  count,
        input  overflow,
        input  underflow
    );

    // The FIFO itself
    modport slave (
        input  flush,
        input  wr,
        input  w_data,
        input  rd,
        output r_data,
        output r_valid,
        output empty,
        output full,
        output almost_empty,
        output almost_full,
        output count,
        output overflow,
        output underflow
    );

endinterface

// File: rtl/fifo_ram_dp.sv
// Simple dual-port register array: synchronous write, asynchronous read.
module fifo_ram_dp
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Storage write; contents are never cleared, only overwritten
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Combinational read so the head word is visible without a clock
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, programmable almost flags,
// overflow/underflow pulses, synchronous flush and selectable read mode.
module fifo_sync_flags
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned AF_THRESH  = 6,
    parameter int unsigned AE_THRESH  = 1,
    parameter int unsigned FWFT       = MODE_FWFT
) (
    input logic              clk,
    input logic              reset,
    fifo_sync_flags_if.slave s_if
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
    localparam int unsigned CNT_W = fifo_cnt_w(ADDR_WIDTH);

    localparam fifo_flags_t FLAGS_RST =
        make_flags(32'(0), DEPTH, AF_THRESH, AE_THRESH, 1'b0, 1'b0);

    // Reject illegal thresholds before anything is built
    if (!af_thresh_ok(AF_THRESH, DEPTH)) begin : g_bad_af
        $error("fifo_sync_flags: AF_THRESH out of range, legal values are 1..DEPTH");
    end
    if (!ae_thresh_ok(AE_THRESH, DEPTH)) begin : g_bad_ae
        $error("fifo_sync_flags: AE_THRESH out of range, legal values are 0..DEPTH-1");
    end
    if ((FWFT != MODE_FWFT) && (FWFT != MODE_REG)) begin : g_bad_mode
        $error("fifo_sync_flags: FWFT must be 0 (registered) or 1 (fall-through)");
    end

    logic [CNT_W-1:0]      w_ptr_q, w_ptr_d;
    logic [CNT_W-1:0]      r_ptr_q, r_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    fifo_flags_t           flags_q, flags_d;

    logic                  rd_ok;
    logic                  wr_ok;
    logic                  wr_drop;
    logic                  rd_drop;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Acceptance: a full FIFO still takes a write when a read frees a slot
    always_comb begin
        rd_ok  = s_if.rd & ~flags_q.empty;
        wr_ok  = s_if.wr & (~flags_q.full | rd_ok);
        ram_we = wr_ok & ~s_if.flush & ~reset;
    end

    // Next pointers, count and flags; flush wins over wr/rd and masks errors
    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        count_d = count_q;
        wr_drop = 1'b0;
        rd_drop = 1'b0;
        if (s_if.flush) begin
            w_ptr_d = '0;
            r_ptr_d = '0;
            count_d = '0;
        end else begin
            if (wr_ok) begin
                w_ptr_d = w_ptr_q + CNT_W'(1);
            end
            if (rd_ok) begin
                r_ptr_d = r_ptr_q + CNT_W'(1);
            end
            count_d = count_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);
            wr_drop = s_if.wr & ~wr_ok;
            rd_drop = s_if.rd & ~rd_ok;
        end
        flags_d = make_flags(32'(count_d), DEPTH, AF_THRESH, AE_THRESH, wr_drop, rd_drop);
    end

    // Pointer, count and flag registers; reset has priority over everything
    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
            flags_q <= FLAGS_RST;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            count_q <= count_d;
            flags_q <= flags_d;
        end
    end

    fifo_ram_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (w_ptr_q[ADDR_WIDTH-1:0]),
        .wdata_i (s_if.w_data),
        .raddr_i (r_ptr_q[ADDR_WIDTH-1:0]),
        .rdata_o (ram_rdata)
    );

    if (FWFT == MODE_FWFT) begin : g_fwft
        // Head word falls through straight from the array
        assign s_if.r_data  = ram_rdata;
        assign s_if.r_valid = ~flags_q.empty;
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
        logic                  r_valid_q, r_valid_d;

        // Capture the popped word; data holds when nothing is popped
        always_comb begin
            r_valid_d = 1'b0;
            r_data_d  = r_data_q;
            if (!s_if.flush && rd_ok) begin
                r_valid_d = 1'b1;
                r_data_d  = ram_rdata;
            end
        end

        // Read-mode output register; flush clears valid but keeps data
        always_ff @(posedge clk) begin
            if (reset) begin
                r_valid_q <= 1'b0;
                r_data_q  <= '0;
            end else begin
                r_valid_q <= r_valid_d;
                r_data_q  <= r_data_d;
            end
        end

        assign s_if.r_data  = r_data_q;
        assign s_if.r_valid = r_valid_q;
    end

    // Status outputs straight from registers
    assign s_if.count        = count_q;
    assign s_if.empty        = flags_q.empty;
    assign s_if.full         = flags_q.full;
    assign s_if.almost_empty = flags_q.almost_empty;
    assign s_if.almost_full  = flags_q.almost_full;
    assign s_if.overflow     = flags_q.overflow;
    assign s_if.underflow    = flags_q.underflow;

    // Wrap-bit pointers must always agree with the separately kept count
    a_ptr_count: assert property (@(posedge clk) disable iff (reset)
        (CNT_W'(w_ptr_q - r_ptr_q) == count_q));

    // Occupancy can never exceed the storage depth
    a_count_range: assert property (@(posedge clk) disable iff (reset)
        (count_q <= CNT_W'(DEPTH)));

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Bench for fifo_sync_flags: one fall-through and one registered-read
// instance share the same stimulus and a queue-based reference model.
module tb_fifo_sync_flags;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AF    = 6;
    localparam int unsigned AE    = 1;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          wr;
    logic          rd;
    logic [DW-1:0] w_data;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] rg_q  [$];
    int unsigned   m_cnt  = 0;
    bit            m_ovf  = 1'b0;
    bit            m_udf  = 1'b0;
    bit            m_rgv  = 1'b0;
    logic [DW-1:0] m_rgd  = '0;
    bit            mon_en = 1'b0;

    fifo_sync_flags_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_fw ();
    fifo_sync_flags_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_rg ();

    assign if_fw.flush  = flush;
    assign if_fw.wr     = wr;
    assign if_fw.w_data = w_data;
    assign if_fw.rd     = rd;
    assign if_rg.flush  = flush;
    assign if_rg.wr     = wr;
    assign if_rg.w_data = w_data;
    assign if_rg.rd     = rd;

    fifo_sync_flags #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)
    ) u_fw (
        .clk   (clk),
        .reset (reset),
        .s_if  (if_fw)
    );

    fifo_sync_flags #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)
    ) u_rg (
        .clk   (clk),
        .reset (reset),
        .s_if  (if_rg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus; the model is advanced to the post-edge state
    task automatic tick(input logic rst, input logic fl, input logic w,
                        input logic [DW-1:0] wd, input logic r);
        bit rok;
        bit wok;
        logic [DW-1:0] v;
        reset  = rst;
        flush  = fl;
        wr     = w;
        w_data = wd;
        rd     = r;
        if (rst) begin
            exp_q.delete();
            rg_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_rgv = 1'b0;
            m_rgd = '0;
        end else if (fl) begin
            exp_q.delete();
            rg_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_rgv = 1'b0;
        end else begin
            rok   = r && (exp_q.size() != 0);
            wok   = w && ((exp_q.size() != int'(DEPTH)) || rok);
            m_udf = r && !rok;
            m_ovf = w && !wok;
            m_rgv = rok;
            if (rok) begin
                v = exp_q.pop_front();
                rg_q.push_back(v);
                m_rgd = v;
            end
            if (wok) exp_q.push_back(wd);
        end
        m_cnt = exp_q.size();
        @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;
        flush = 1'b0;
        wr    = 1'b0;
        rd    = 1'b0;
    endtask

    // Scoreboard monitor: status of both instances and the read data stream
    logic [9:0]    exp_st;
    logic [9:0]    act_fw;
    logic [9:0]    act_rg;
    logic [DW-1:0] rg_exp;
    always @(negedge clk) begin
        if (mon_en) begin
            exp_st = {m_cnt == 0, m_cnt == DEPTH, m_cnt <= AE, m_cnt >= AF,
                      m_ovf, m_udf, 4'(m_cnt)};
            act_fw = {if_fw.empty, if_fw.full, if_fw.almost_empty, if_fw.almost_full,
                      if_fw.overflow, if_fw.underflow, if_fw.count};
            act_rg = {if_rg.empty, if_rg.full, if_rg.almost_empty, if_rg.almost_full,
                      if_rg.overflow, if_rg.underflow, if_rg.count};
            checks++;
            if (act_fw !== exp_st) begin
                errors++;
                $display("FAIL fw_status at %0t: got %b expected %b", $time, act_fw, exp_st);
            end
            checks++;
            if (act_rg !== exp_st) begin
                errors++;
                $display("FAIL rg_status at %0t: got %b expected %b", $time, act_rg, exp_st);
            end
            checks++;
            if (if_fw.r_valid !== (m_cnt != 0)) begin
                errors++;
                $display("FAIL fw_r_valid at %0t: got %b expected %b", $time, if_fw.r_valid, m_cnt != 0);
            end
            if (m_cnt != 0) begin
                checks++;
                if (if_fw.r_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL fw_r_data at %0t: got %h expected %h", $time, if_fw.r_data, exp_q[0]);
                end
            end
            checks++;
            if (if_rg.r_valid !== m_rgv) begin
                errors++;
                $display("FAIL rg_r_valid at %0t: got %b expected %b", $time, if_rg.r_valid, m_rgv);
            end
            if (m_rgv) begin
                checks++;
                if (rg_q.size() == 0) begin
                    errors++;
                    $display("FAIL rg_scoreboard at %0t: got output with no queued word", $time);
                end else begin
                    rg_exp = rg_q.pop_front();
                    if (if_rg.r_data !== rg_exp) begin
                        errors++;
                        $display("FAIL rg_r_data at %0t: got %h expected %h", $time, if_rg.r_data, rg_exp);
                    end
                end
            end else begin
                checks++;
                if (if_rg.r_data !== m_rgd) begin
                    errors++;
                    $display("FAIL rg_r_data_hold at %0t: got %h expected %h", $time, if_rg.r_data, m_rgd);
                end
            end
        end
    end

    task automatic test_reset();
        tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (if_fw.count !== 4'd0 || if_fw.empty !== 1'b1 || if_fw.almost_empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_flags: got count=%0d empty=%b ae=%b expected 0 1 1",
                     if_fw.count, if_fw.empty, if_fw.almost_empty);
        end
        checks++;
        if (if_rg.r_data !== 8'h00 || if_rg.r_valid !== 1'b0 || if_fw.r_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_read: got rg_data=%h rg_valid=%b fw_valid=%b expected 00 0 0",
                     if_rg.r_data, if_rg.r_valid, if_fw.r_valid);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b0, 1'b1, 8'((i + 1) * 17), 1'b0);
            checks++;
            if (if_fw.count !== 4'(i + 1)) begin
                errors++;
                $display("FAIL fill_count: got %0d expected %0d", if_fw.count, i + 1);
            end
            checks++;
            if (if_rg.almost_full !== (i >= 5)) begin
                errors++;
                $display("FAIL fill_almost_full: got %b expected %b at count %0d",
                         if_rg.almost_full, i >= 5, i + 1);
            end
        end
        checks++;
        if (if_fw.full !== 1'b1) begin
            errors++;
            $display("FAIL fill_full: got %b expected 1", if_fw.full);
        end
        tick(1'b0, 1'b0, 1'b1, 8'h99, 1'b0);
        checks++;
        if (if_fw.overflow !== 1'b1 || if_rg.overflow !== 1'b1 || if_fw.count !== 4'd8) begin
            errors++;
            $display("FAIL overflow_pulse: got ovf=%b/%b count=%0d expected 1/1 8",
                     if_fw.overflow, if_rg.overflow, if_fw.count);
        end
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (if_fw.overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_one_cycle: got %b expected 0", if_fw.overflow);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (if_fw.r_data !== 8'((i + 1) * 17)) begin
                errors++;
                $display("FAIL drain_fw_data: got %h expected %h", if_fw.r_data, 8'((i + 1) * 17));
            end
            tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            checks++;
            if (if_rg.r_valid !== 1'b1 || if_rg.r_data !== 8'((i + 1) * 17)) begin
                errors++;
                $display("FAIL drain_rg_data: got valid=%b data=%h expected 1 %h",
                         if_rg.r_valid, if_rg.r_data, 8'((i + 1) * 17));
            end
        end
        checks++;
        if (if_fw.empty !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty: got %b expected 1", if_fw.empty);
        end
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (if_fw.underflow !== 1'b1 || if_rg.underflow !== 1'b1 || if_rg.r_valid !== 1'b0) begin
            errors++;
            $display("FAIL underflow_pulse: got udf=%b/%b rg_valid=%b expected 1/1 0",
                     if_fw.underflow, if_rg.underflow, if_rg.r_valid);
        end
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (if_rg.underflow !== 1'b0) begin
            errors++;
            $display("FAIL underflow_one_cycle: got %b expected 0", if_rg.underflow);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0, 1'b1, 8'(8'h30 + i), 1'b1);
            checks++;
            if (if_fw.underflow !== (i == 0) || if_fw.count !== 4'd1) begin
                errors++;
                $display("FAIL b2b_status cycle %0d: got udf=%b count=%0d expected %b 1",
                         i, if_fw.underflow, if_fw.count, i == 0);
            end
            if (i > 0) begin
                checks++;
                if (if_rg.r_data !== 8'(8'h30 + i - 1)) begin
                    errors++;
                    $display("FAIL b2b_order cycle %0d: got %h expected %h",
                             i, if_rg.r_data, 8'(8'h30 + i - 1));
                end
            end
        end
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
        tick(1'b0, 1'b0, 1'b1, 8'hEE, 1'b1);
        checks++;
        if (if_fw.overflow !== 1'b0 || if_fw.count !== 4'd8 || if_rg.full !== 1'b1) begin
            errors++;
            $display("FAIL full_rw_status: got ovf=%b count=%0d full=%b expected 0 8 1",
                     if_fw.overflow, if_fw.count, if_rg.full);
        end
        checks++;
        if (if_rg.r_data !== 8'h40 || if_fw.r_data !== 8'h41) begin
            errors++;
            $display("FAIL full_rw_head: got rg=%h fw=%h expected 40 41", if_rg.r_data, if_fw.r_data);
        end
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (if_rg.r_data !== 8'hEE || if_fw.empty !== 1'b1) begin
            errors++;
            $display("FAIL full_rw_tail: got last=%h empty=%b expected ee 1", if_rg.r_data, if_fw.empty);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b1, 8'(8'h50 + i), 1'b0);
        tick(1'b0, 1'b1, 1'b1, 8'h77, 1'b1);
        checks++;
        if (if_fw.count !== 4'd0 || if_fw.empty !== 1'b1 || if_fw.almost_empty !== 1'b1) begin
            errors++;
            $display("FAIL flush_flags: got count=%0d empty=%b ae=%b expected 0 1 1",
                     if_fw.count, if_fw.empty, if_fw.almost_empty);
        end
        checks++;
        if (if_rg.overflow !== 1'b0 || if_rg.underflow !== 1'b0 || if_rg.r_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_pulses: got ovf=%b udf=%b rg_valid=%b expected 0 0 0",
                     if_rg.overflow, if_rg.underflow, if_rg.r_valid);
        end
        tick(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0);
        checks++;
        if (if_fw.r_data !== 8'hA5) begin
            errors++;
            $display("FAIL flush_first_fw: got %h expected a5", if_fw.r_data);
        end
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (if_rg.r_data !== 8'hA5 || if_rg.r_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_first_rg: got %h valid=%b expected a5 1", if_rg.r_data, if_rg.r_valid);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b1, 8'(8'h60 + i), 1'b0);
        tick(1'b1, 1'b0, 1'b1, 8'hBB, 1'b0);
        checks++;
        if (if_fw.count !== 4'd0 || if_fw.empty !== 1'b1 || if_fw.full !== 1'b0 ||
            if_fw.almost_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_flags: got count=%0d empty=%b full=%b af=%b expected 0 1 0 0",
                     if_fw.count, if_fw.empty, if_fw.full, if_fw.almost_full);
        end
        checks++;
        if (if_rg.r_data !== 8'h00 || if_rg.r_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_read: got %h valid=%b expected 00 0", if_rg.r_data, if_rg.r_valid);
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b0, 1'b1, 8'(8'h70 + i), 1'b0);
            checks++;
            if (if_rg.full !== (i == 7)) begin
                errors++;
                $display("FAIL reset_mid_full after %0d writes: got %b expected %b",
                         i + 1, if_rg.full, i == 7);
            end
        end
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (if_rg.r_data !== 8'h77) begin
            errors++;
            $display("FAIL reset_mid_last: got %h expected 77", if_rg.r_data);
        end
    endtask

    initial begin
        reset  = 1'b0;
        flush  = 1'b0;
        wr     = 1'b0;
        rd     = 1'b0;
        w_data = '0;
        mon_en = 1'b1;
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_full_rw();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Run-away guard
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by %0t expected finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
